// File: rtl/mem2hex_serial.sv
// Drains 48-bit LPC capture records from the ring buffer and prints each one as
// a printable ASCII hex line through the uart_tx byte strobe/ready handshake.
module mem2hex_serial #(
  parameter bit LINE_CRLF = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_empty,
  input  logic [47:0] read_data,
  output logic        read_clock_enable,
  input  logic        uart_ready,
  output logic        uart_clock_enable,
  output logic [7:0]  uart_data
);

  localparam logic [3:0] LAST_INDEX = LINE_CRLF ? 4'd14 : 4'd13;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t      state;
  logic [3:0]  char_index;
  logic [31:0] rec_addr;
  logic [7:0]  rec_data;
  logic [3:0]  rec_cyc;
  logic [7:0]  next_char;

  // Record bits [7:4] are padding and intentionally not latched.
  logic unused_pad;
  assign unused_pad = ^read_data[7:4];

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h0, nib} + 8'h30;
    return {4'h0, nib} + 8'h37;
  endfunction

  always_comb begin
    next_char = 8'h0A;
    case (char_index)
      4'd0:         next_char = hex_ascii(rec_cyc);
      4'd1, 4'd10:  next_char = 8'h20;
      4'd2:         next_char = hex_ascii(rec_addr[31:28]);
      4'd3:         next_char = hex_ascii(rec_addr[27:24]);
      4'd4:         next_char = hex_ascii(rec_addr[23:20]);
      4'd5:         next_char = hex_ascii(rec_addr[19:16]);
      4'd6:         next_char = hex_ascii(rec_addr[15:12]);
      4'd7:         next_char = hex_ascii(rec_addr[11:8]);
      4'd8:         next_char = hex_ascii(rec_addr[7:4]);
      4'd9:         next_char = hex_ascii(rec_addr[3:0]);
      4'd11:        next_char = hex_ascii(rec_data[7:4]);
      4'd12:        next_char = hex_ascii(rec_data[3:0]);
      4'd13:        next_char = LINE_CRLF ? 8'h0D : 8'h0A;
      default:      next_char = 8'h0A;
    endcase
  end

  // HOLD exists so the stale uart_ready of the strobe cycle is never sampled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      char_index        <= 4'd0;
      rec_addr          <= 32'h0;
      rec_data          <= 8'h0;
      rec_cyc           <= 4'h0;
      read_clock_enable <= 1'b0;
      uart_clock_enable <= 1'b0;
      uart_data         <= 8'h00;
    end else begin
      read_clock_enable <= 1'b0;
      uart_clock_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (!read_empty) begin
            rec_addr          <= read_data[47:16];
            rec_data          <= read_data[15:8];
            rec_cyc           <= read_data[3:0];
            read_clock_enable <= 1'b1;
            char_index        <= 4'd0;
            state             <= SEND;
          end
        end
        SEND: begin
          if (uart_ready) begin
            uart_data         <= next_char;
            uart_clock_enable <= 1'b1;
            state             <= HOLD;
          end
        end
        HOLD: begin
          if (char_index == LAST_INDEX) begin
            state <= IDLE;
          end else begin
            char_index <= char_index + 4'd1;
            state      <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem2hex_serial.sv
// Directed bench for mem2hex_serial: one LF-only and one CR LF instance, each fed
// by a small ring-buffer model and a UART model with configurable ready holdoff.
module tb_mem2hex_serial;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Index 0 is the LF-only instance, index 1 the CR LF instance.
  logic        empty_s [2];
  logic [47:0] rdata_s [2];
  logic        pop_s   [2];
  logic        ready_s [2] = '{1'b1, 1'b1};
  logic        stb_s   [2];
  logic [7:0]  udata_s [2];

  logic [47:0] rec_mem [2][16];
  int          rec_head [2] = '{0, 0};
  int          rec_tail [2] = '{0, 0};

  assign empty_s[0] = (rec_head[0] == rec_tail[0]);
  assign empty_s[1] = (rec_head[1] == rec_tail[1]);
  assign rdata_s[0] = rec_mem[0][rec_head[0]];
  assign rdata_s[1] = rec_mem[1][rec_head[1]];

  mem2hex_serial #(.LINE_CRLF(1'b0)) dut_lf (
    .clock(clock), .reset(reset),
    .read_empty(empty_s[0]), .read_data(rdata_s[0]), .read_clock_enable(pop_s[0]),
    .uart_ready(ready_s[0]), .uart_clock_enable(stb_s[0]), .uart_data(udata_s[0])
  );

  mem2hex_serial #(.LINE_CRLF(1'b1)) dut_crlf (
    .clock(clock), .reset(reset),
    .read_empty(empty_s[1]), .read_data(rdata_s[1]), .read_clock_enable(pop_s[1]),
    .uart_ready(ready_s[1]), .uart_clock_enable(stb_s[1]), .uart_data(udata_s[1])
  );

  int total = 0;
  int bad   = 0;

  int         cyc = 0;
  int         byte_n     [2] = '{0, 0};
  int         base_n     [2] = '{0, 0};
  int         pop_n      [2] = '{0, 0};
  int         pop_base   [2] = '{0, 0};
  int         last_stb   [2] = '{0, 0};
  int         hold_cfg   [2] = '{0, 0};
  int         hold_cnt   [2] = '{0, 0};
  logic       ready_prev [2] = '{1'b1, 1'b1};
  int         ready_viol [2] = '{0, 0};
  int         gap_bad    [2] = '{0, 0};
  int         early_pop  [2] = '{0, 0};
  int         late_pop   [2] = '{0, 0};
  logic [7:0] byte_log   [2][128];
  int         pos_m;
  int         len_m;

  // Ring buffer and UART models plus protocol monitors, all on the falling edge.
  always @(negedge clock) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      len_m = (d == 1) ? 15 : 14;
      if (stb_s[d]) begin
        pos_m = (byte_n[d] - base_n[d]) % len_m;
        if (!ready_prev[d]) ready_viol[d]++;
        if (pos_m != 0 && (cyc - last_stb[d]) != 2) gap_bad[d]++;
        if (pos_m == 0 && (pop_n[d] - pop_base[d]) != ((byte_n[d] - base_n[d]) / len_m) + 1)
          late_pop[d]++;
        if (byte_n[d] < 128) byte_log[d][byte_n[d]] = udata_s[d];
        byte_n[d]++;
        last_stb[d] = cyc;
        if (hold_cfg[d] > 0) begin
          ready_s[d]  = 1'b0;
          hold_cnt[d] = hold_cfg[d];
        end
      end else if (hold_cnt[d] > 0) begin
        hold_cnt[d]--;
        if (hold_cnt[d] == 0) ready_s[d] = 1'b1;
      end
      if (pop_s[d]) begin
        if (((byte_n[d] - base_n[d]) % len_m) != 0) early_pop[d]++;
        pop_n[d]++;
        if (rec_head[d] < rec_tail[d]) rec_head[d]++;
      end
      ready_prev[d] = ready_s[d];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic [47:0] rec);
    rec_mem[d][rec_tail[d]] = rec;
    rec_tail[d]++;
  endtask

  task automatic waitBytes(input int d, input int target, input int budget);
    int n = 0;
    while (byte_n[d] < target && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    checkOutput($sformatf("bytes_reached_d%0d", d), 64'(byte_n[d] >= target), 64'd1);
  endtask

  function automatic logic [7:0] expChar(input logic [47:0] rec, input int pos, input bit crlf);
    string hx;
    hx = "0123456789ABCDEF";
    if (pos == 0) return hx[int'(rec[3:0])];
    if (pos == 1 || pos == 10) return 8'h20;
    if (pos >= 2 && pos <= 9) return hx[int'(rec[47 - 4*(pos-2) -: 4])];
    if (pos == 11) return hx[int'(rec[15:12])];
    if (pos == 12) return hx[int'(rec[11:8])];
    if (pos == 13) return crlf ? 8'h0D : 8'h0A;
    return 8'h0A;
  endfunction

  task automatic checkLine(input int d, input int start, input logic [47:0] rec);
    int len;
    len = (d == 1) ? 15 : 14;
    for (int p = 0; p < len; p++)
      checkOutput($sformatf("d%0d_byte%0d", d, start + p), byte_log[d][start + p],
                  expChar(rec, p, d == 1));
  endtask

  logic [7:0] exp_crlf [15] = '{8'h31, 8'h20, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
                                8'h38, 8'h30, 8'h20, 8'h35, 8'h41, 8'h0D, 8'h0A};
  logic [7:0] exp_lf   [14] = '{8'h46, 8'h20, 8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41,
                                8'h39, 8'h38, 8'h20, 8'h46, 8'h46, 8'h0A};

  logic [47:0] rec3, rec4a, rec4b, rec4c, rec5a, rec5b;

  initial begin
    rec3  = {32'h1234_5678, 8'hC3, 4'hA, 4'h2};
    rec4a = {32'hDEAD_BEEF, 8'h00, 4'h0, 4'h3};
    rec4b = {32'h0000_0000, 8'h9F, 4'h0, 4'hC};
    rec4c = {32'h89AB_CDEF, 8'h01, 4'h0, 4'h7};
    rec5a = {32'h0BAD_F00D, 8'h42, 4'h0, 4'h5};
    rec5b = {32'h7654_3210, 8'hE1, 4'h0, 4'h9};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) rec_mem[d][i] = 48'h0;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_pop", pop_s[1], 1'b0);
    checkOutput("reset_stb", stb_s[1], 1'b0);
    checkOutput("reset_data", udata_s[1], 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Empty buffer for 1000 cycles: nothing may happen.
    repeat (1000) @(negedge clock);
    #1;
    checkOutput("idle_bytes", byte_n[0] + byte_n[1], 0);
    checkOutput("idle_pops", pop_n[0] + pop_n[1], 0);
    checkOutput("idle_data_lf", udata_s[0], 8'h00);
    checkOutput("idle_data_crlf", udata_s[1], 8'h00);

    // Single CR LF record, ready always high.
    @(negedge clock);
    applyStimulus(1, {32'h0000_0080, 8'h5A, 4'h0, 4'h1});
    @(negedge clock);
    checkOutput("pop_latency", pop_s[1], 1'b1);
    waitBytes(1, 15, 100);
    repeat (4) @(negedge clock);
    #1;
    for (int i = 0; i < 15; i++)
      checkOutput($sformatf("crlf_vec_byte%0d", i), byte_log[1][i], exp_crlf[i]);
    checkOutput("crlf_pops", pop_n[1], 1);
    checkOutput("crlf_gap", gap_bad[1], 0);

    // LF-only record with all-ones fields.
    applyStimulus(0, {32'hFEDC_BA98, 8'hFF, 4'h0, 4'hF});
    waitBytes(0, 14, 100);
    repeat (4) @(negedge clock);
    #1;
    for (int i = 0; i < 14; i++)
      checkOutput($sformatf("lf_vec_byte%0d", i), byte_log[0][i], exp_lf[i]);
    checkOutput("lf_pops", pop_n[0], 1);

    // Slow UART: ready low for 100 cycles after every strobe.
    hold_cfg[0] = 100;
    applyStimulus(0, rec3);
    waitBytes(0, 28, 3000);
    hold_cfg[0] = 0;
    repeat (110) @(negedge clock);
    #1;
    checkLine(0, 14, rec3);
    checkOutput("slow_ready_viol", ready_viol[0], 0);
    checkOutput("slow_pops", pop_n[0], 2);

    // Three queued records back to back.
    applyStimulus(1, rec4a);
    applyStimulus(1, rec4b);
    applyStimulus(1, rec4c);
    waitBytes(1, 60, 600);
    repeat (6) @(negedge clock);
    #1;
    checkLine(1, 15, rec4a);
    checkLine(1, 30, rec4b);
    checkLine(1, 45, rec4c);
    checkOutput("b2b_pops", pop_n[1], 4);
    checkOutput("b2b_early_pop", early_pop[1], 0);
    checkOutput("b2b_late_pop", late_pop[1], 0);
    checkOutput("b2b_gap", gap_bad[1], 0);
    checkOutput("crlf_ready_viol", ready_viol[1], 0);

    // Reset after the sixth byte of a line; the next record starts clean.
    applyStimulus(0, rec5a);
    applyStimulus(0, rec5b);
    waitBytes(0, 34, 200);
    #2;
    checkOutput("pre_reset_data", udata_s[0], expChar(rec5a, 5, 1'b0));
    reset = 1'b1;
    #1;
    checkOutput("midline_reset_pop", pop_s[0], 1'b0);
    checkOutput("midline_reset_stb", stb_s[0], 1'b0);
    checkOutput("midline_reset_data", udata_s[0], 8'h00);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    base_n[0]   = byte_n[0];
    pop_base[0] = pop_n[0];
    waitBytes(0, base_n[0] + 14, 200);
    repeat (4) @(negedge clock);
    #1;
    checkLine(0, base_n[0], rec5b);
    checkOutput("post_reset_pops", pop_n[0] - pop_base[0], 1);
    checkOutput("lf_early_pop", early_pop[0], 0);
    checkOutput("lf_late_pop", late_pop[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem2hex_serial.md
# mem2hex_serial

Downstream drain stage between the LPC sniffer ring buffer and the UART transmitter. It pops one 48-bit record at a time from the ring buffer and renders it as a printable ASCII hex line: cycle-type/direction digit, address, data, line terminator. It drives the byte strobe/ready handshake of `uart_tx`, so a plain terminal can show captured LPC traffic without a host-side decoder.

## Interface
- `LINE_CRLF`, default 1: 1 = lines end in CR LF (15 chars per record); 0 = LF only (14 chars).
- `clock`  in  1  system clock (`ext_clock` domain, same as ring buffer and UART).
- `reset`  in  1  asynchronous, active-high reset.
- `read_empty`  in  1  ring buffer empty flag.
- `read_data`  in  48  head record, show-ahead: valid whenever `read_empty`=0. [47:16] address, [15:8] data, [7:4] zero, [3:0] cyctype_dir.
- `read_clock_enable`  out  1  one-cycle pop strobe to ring buffer.
- `uart_ready`  in  1  UART idle and able to accept a byte.
- `uart_clock_enable`  out  1  one-cycle byte strobe to UART.
- `uart_data`  out  8  byte to transmit, valid while `uart_clock_enable`=1.

## Operation
- All outputs registered. Reset values: `read_clock_enable`=0, `uart_clock_enable`=0, `uart_data`=8'h00. State = IDLE, char index = 0, record latch = 0.
- States: IDLE, SEND, HOLD.
- IDLE: if `read_empty`=0, latch `read_data`, pulse `read_clock_enable` for 1 cycle, index←0, go to SEND. Otherwise stay.
- SEND: if `uart_ready`=1, drive `uart_data`=char[index] and `uart_clock_enable`=1 on the next edge, then go to HOLD. Otherwise wait in SEND; the strobe stays 0.
- HOLD: lasts exactly 1 cycle, the cycle in which the strobe is visible. Deassert the strobe on the next edge.
  - If index = last, go to IDLE.
  - Else index←index+1 and go to SEND.
- Character order, index 0..14:
  - cyctype_dir[3:0]
  - space (8'h20)
  - addr[31:28] down to addr[3:0], 8 digits
  - space
  - data[7:4], data[3:0]
  - CR (8'h0D), only when `LINE_CRLF`=1
  - LF (8'h0A)
- Nibble to ASCII: 0–9 → nibble+8'h30; A–F → nibble+8'h37, uppercase. Add in 8 bits, zero-extending the nibble.
- Index counter is 4 bits. Last index = 14 when `LINE_CRLF`=1, 13 when 0. The index never wraps past last.
- Record bits [7:4] are ignored.
- Exactly one pop per line; a record is never sent twice or skipped.
- `read_data` changes while SEND/HOLD are active have no effect; the latched copy is used.
- Reset mid-line: the line is abandoned immediately and outputs return to reset values. The popped record is lost and no pop is issued. After reset release, the next record starts a fresh line at index 0.
- `read_empty` rising during a line has no effect. `read_empty` falling in the same cycle the last HOLD completes: IDLE samples it on the next cycle.

## Timing
- Pop latency: `read_empty` seen low in IDLE at cycle t → `read_clock_enable`=1 during cycle t+1, state SEND at t+1.
- Byte latency: SEND with `uart_ready`=1 at cycle t → strobe during t+1 (HOLD) → SEND again at t+2.
- Best case: 2 cycles per byte; a 15-byte line plus pop takes ≥31 cycles.
- UART contract: `uart_ready` must read 0 from the cycle after the strobe until that byte completes. The HOLD cycle provides the single-cycle holdoff, so a stale `uart_ready`=1 is never sampled.
- Ring buffer contract: `read_empty` and `read_data` must reflect the pop within ≤28 cycles. This is met, since the line takes longer than that.
- Back-to-back records: the last HOLD → IDLE → pop, giving a 2-cycle gap before the next line's SEND.

## Test plan
- Record {addr 32'h0000_0080, data 8'h5A, cyc 4'h1}, `uart_ready` always 1 → bytes 31 20 30 30 30 30 30 30 38 30 20 35 41 0D 0A. One `read_clock_enable` pulse; strobes spaced exactly 2 cycles apart.
- `LINE_CRLF`=0, record {32'hFEDC_BA98, 8'hFF, 4'hF} → 46 20 46 45 44 43 42 41 39 38 20 46 46 0A (14 bytes).
- UART model holding ready low for 100 cycles after each strobe → no strobe while ready=0; byte sequence unchanged; no extra pops.
- Three records queued, `read_empty`=0 throughout → 3 pops, each pop before its line's first byte, 45 bytes in order. No second pop until the previous LF strobe has completed.
- `reset` asserted asynchronously after byte 6 → all outputs 0 within the same cycle. After release, the next queued record prints from index 0 with no partial tail.
- `read_empty`=1 held for 1000 cycles → zero strobes and zero pops; `uart_data` stays 8'h00.
